// File: rtl/penc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Vectors handed to onehot_or_zero are zero-extended to PENC_MAX_W bits.
package penc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int PENC_MAX_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // True for zero or exactly one bit set.
  function automatic logic onehot_or_zero(input logic [PENC_MAX_W-1:0] v);
    return (v & (v - 64'd1)) == '0;
  endfunction

endpackage

// File: rtl/priority_encoder_seq_find.sv
// Combinational highest-set-bit finder; any_o flags a nonzero vector.
// Latency 0, no handshake.
module priority_find #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/priority_encoder_seq.sv
// Serialises a request vector into one index beat per set bit, highest first.
// Optional PENC_ZERO_BEAT_EN: an all-zero vector yields one beat with out_zero=1.
module priority_encoder_seq
  import penc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
`ifdef PENC_ZERO_BEAT_EN
  ,
  output logic             out_zero
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pend_any;

  priority_find #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_find (
    .vec_i (pending_q),
    .idx_o (out_idx),
    .any_o (pend_any)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  // A zero pending word in SCAN only occurs for the zero beat, which is also final.
  assign out_last  = (state_q == SCAN) && onehot_or_zero(PENC_MAX_W'(pending_q));

`ifdef PENC_ZERO_BEAT_EN
  assign out_zero  = (state_q == SCAN) && !pend_any;
`else
  logic unused_any;
  assign unused_any = pend_any;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_data;
`ifdef PENC_ZERO_BEAT_EN
          state_d = SCAN;
`else
          if (|in_data) state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(ONE << out_idx);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
